program_loader: RTL and testbench
=================================

# program_loader

Boot-time program loader for the 16-bit multicycle processor. It accepts a framed byte stream from a serial receiver and assembles it into 16-bit instruction/data words. Each word is written into main memory through the memory write port, while the processor is held in reset. Once a frame passes its checksum, it releases the CPU to start fetching at BASE_ADDR.

## Interface
- BASE_ADDR, 16'h0000, memory address of the first loaded word
- ADDR_STEP, 16'd2, address increment per word; matches the PC increment of 2
- MAX_WORDS, 500, largest accepted word count; matches memory depth
- CLK  input  1  system clock; all state changes on the rising edge
- RESET_N  input  1  asynchronous, active-low reset
- START  input  1  one-cycle pulse; begins a load when in IDLE, DONE or ERR, and is ignored in every other state
- RX_DATA  input  8  received byte
- RX_VALID  input  1  RX_DATA is valid
- RX_READY  output  1  loader can accept a byte; a byte is transferred on an edge where RX_VALID && RX_READY
- LD_ADDR  output  16  memory write address
- LD_DATA  output  16  memory write data
- LD_WE  output  1  memory write strobe, one cycle per word
- CPU_HOLD  output  1  drives the processor RESET; high whenever the CPU must not run
- DONE  output  1  load completed with a good checksum
- ERROR  output  2  00 none, 01 length overflow, 10 checksum mismatch
- WORD_CNT  output  16  number of words written in the current load

Clocking and reset (decided): single clock CLK; reset RESET_N is asynchronous and active-low.

## Operation
- Frame format, in order:
  - LEN_LO, LEN_HI: word count N, little-endian.
  - 2N data bytes: each word is low byte then high byte, so word = {hi, lo}.
  - One checksum byte.
- Checksum rule: the 8-bit sum of every frame byte, including the length bytes and the checksum byte itself, must equal 8'h00 (mod 256).
- States: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CHECK, DONE, ERR.
- IDLE: START moves to LEN_LO. The running sum and WORD_CNT clear to 0, ERROR clears to 00 and DONE clears to 0.
- LEN_LO: accept a byte, then go to LEN_HI.
- LEN_HI: accept a byte, then branch:
  - N > MAX_WORDS: go to ERR with ERROR=01.
  - N == 0: go to CHECK.
  - Otherwise: go to DATA_LO.
- DATA_LO: accept a byte, then go to DATA_HI.
- DATA_HI: accept a byte, then go to WRITE.
- WRITE: for exactly one cycle, LD_WE=1, LD_ADDR = BASE_ADDR + WORD_CNT*ADDR_STEP (16-bit wrap) and LD_DATA = {hi, lo}. On leaving WRITE, WORD_CNT increments. Next state is CHECK if the new WORD_CNT == N, else DATA_LO.
- CHECK: accept the checksum byte. If (sum + byte) mod 256 == 0, go to DONE; otherwise go to ERR with ERROR=10.
- DONE: DONE=1 and CPU_HOLD=0. Stay until START.
- ERR: CPU_HOLD=1 and ERROR holds its code. Stay until START.
- Words written before an error are not rolled back.
- RX_READY=1 only in LEN_LO, LEN_HI, DATA_LO, DATA_HI and CHECK. It is 0 in IDLE, WRITE, DONE and ERR.
- LD_ADDR and LD_DATA hold their last values when LD_WE=0.

## Timing
- Reset values:
  - State IDLE, RX_READY=0, LD_WE=0.
  - LD_ADDR=0, LD_DATA=0, CPU_HOLD=1, DONE=0, ERROR=00, WORD_CNT=0.
- The CPU is held from reset until the first good load; it is held again by any START.
- RESET_N asserted mid-load: immediate return to reset values. Any partial word in progress is discarded.
- Each state that accepts a byte consumes exactly one byte and advances on the same edge. With RX_VALID=0 the loader waits indefinitely, with no timeout.
- Per word: at least 3 cycles (DATA_LO, DATA_HI, WRITE).
  - LD_WE is high in the cycle after the edge that accepted the high byte.
  - During WRITE, RX_READY=0, so a byte presented then must be held by the sender.
- DONE and CPU_HOLD change on the edge that accepts a good checksum.
- ERROR changes on the edge that accepts the failing byte (LEN_HI or CHECK).
- START coinciding with an accepted byte in a non-idle state is ignored.

## Test plan
- Good frame 02 00 34 12 78 56 EA, RX_VALID held high:
  - LD_WE pulses at (0x0000, 0x1234), then (0x0002, 0x5678).
  - WORD_CNT=2, DONE=1, CPU_HOLD=0, ERROR=00.
- Bad checksum, same frame ending EB:
  - Both writes still occur.
  - ERROR=10, DONE=0, CPU_HOLD=1, RX_READY=0.
- Length overflow, frame F5 01 (N=501):
  - ERR after the second byte, ERROR=01, no LD_WE, later bytes not accepted.
- Zero length, frame 00 00 00:
  - DONE=1, no LD_WE, WORD_CNT=0.
- Backpressure: good frame from the first test with RX_VALID toggled randomly and a byte presented during WRITE.
  - Identical writes occur.
  - No byte lost or duplicated; RX_READY=0 exactly in WRITE cycles.
- Reset mid-load: RESET_N pulsed low after the first word is written.
  - All outputs return to reset values.
  - A following START plus the good frame reproduces the first test's results.

Source files
------------

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot-time framed byte stream loader into main memory
// Holds the CPU in reset until a frame with a good checksum has been written.
module program_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] ADDR_STEP = 16'd2,
  parameter int unsigned MAX_WORDS = 500
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic        RX_READY,
  output logic [15:0] LD_ADDR,
  output logic [15:0] LD_DATA,
  output logic        LD_WE,
  output logic        CPU_HOLD,
  output logic        DONE,
  output logic [1:0]  ERROR,
  output logic [15:0] WORD_CNT
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LEN_LO  = 4'd1,
    S_LEN_HI  = 4'd2,
    S_DATA_LO = 4'd3,
    S_DATA_HI = 4'd4,
    S_WRITE   = 4'd5,
    S_CHECK   = 4'd6,
    S_DONE    = 4'd7,
    S_ERR     = 4'd8
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_SUM  = 2'b10;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_sum;
  logic [7:0]  r_len_lo;
  logic [15:0] r_len;
  logic [7:0]  r_lo;
  logic [15:0] r_ld_addr;
  logic [15:0] r_ld_data;
  logic [15:0] r_word_cnt;
  logic [1:0]  r_error;

  logic        w_rx_ready;
  logic        w_take;
  logic        w_start_ok;
  logic [15:0] w_len_full;
  logic        w_len_over;
  logic [15:0] w_cnt_next;
  logic [7:0]  w_sum_next;
  logic [15:0] w_addr;

  assign w_take     = RX_VALID && w_rx_ready;
  assign w_start_ok = START && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
  assign w_len_full = {RX_DATA, r_len_lo};
  assign w_len_over = {16'd0, w_len_full} > MAX_WORDS;
  assign w_cnt_next = r_word_cnt + 16'd1;
  assign w_sum_next = r_sum + RX_DATA;
  assign w_addr     = BASE_ADDR + r_word_cnt * ADDR_STEP;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (START) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (w_take) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (w_take) begin
          if (w_len_over)               w_next = S_ERR;
          else if (w_len_full == 16'd0) w_next = S_CHECK;
          else                          w_next = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (w_take) w_next = S_DATA_HI;
      end
      S_DATA_HI: begin
        if (w_take) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_next = (w_cnt_next == r_len) ? S_CHECK : S_DATA_LO;
      end
      S_CHECK: begin
        if (w_take) w_next = (w_sum_next == 8'h00) ? S_DONE : S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rx_ready = 1'b0;
    LD_WE      = 1'b0;
    DONE       = 1'b0;
    CPU_HOLD   = 1'b1;
    case (r_state)
      S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CHECK: w_rx_ready = 1'b1;
      S_WRITE: LD_WE = 1'b1;
      S_DONE: begin
        DONE     = 1'b1;
        CPU_HOLD = 1'b0;
      end
      default: ;
    endcase
  end

  // Address and data are latched as the high byte arrives so they are stable for the whole WRITE cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sum      <= 8'h00;
      r_len_lo   <= 8'h00;
      r_len      <= 16'd0;
      r_lo       <= 8'h00;
      r_ld_addr  <= 16'd0;
      r_ld_data  <= 16'd0;
      r_word_cnt <= 16'd0;
      r_error    <= ERR_NONE;
    end else if (w_start_ok) begin
      r_sum      <= 8'h00;
      r_word_cnt <= 16'd0;
      r_error    <= ERR_NONE;
    end else begin
      if (w_take) r_sum <= w_sum_next;
      case (r_state)
        S_LEN_LO: begin
          if (w_take) r_len_lo <= RX_DATA;
        end
        S_LEN_HI: begin
          if (w_take) begin
            r_len <= w_len_full;
            if (w_len_over) r_error <= ERR_LEN;
          end
        end
        S_DATA_LO: begin
          if (w_take) r_lo <= RX_DATA;
        end
        S_DATA_HI: begin
          if (w_take) begin
            r_ld_data <= {RX_DATA, r_lo};
            r_ld_addr <= w_addr;
          end
        end
        S_WRITE: r_word_cnt <= w_cnt_next;
        S_CHECK: begin
          if (w_take && w_sum_next != 8'h00) r_error <= ERR_SUM;
        end
        default: ;
      endcase
    end
  end

  assign RX_READY = w_rx_ready;
  assign LD_ADDR  = r_ld_addr;
  assign LD_DATA  = r_ld_data;
  assign WORD_CNT = r_word_cnt;
  assign ERROR    = r_error;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

  typedef logic [7:0] u8_t;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        START = 1'b0;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_VALID = 1'b0;
  logic        RX_READY;
  logic [15:0] LD_ADDR;
  logic [15:0] LD_DATA;
  logic        LD_WE;
  logic        CPU_HOLD;
  logic        DONE;
  logic [1:0]  ERROR;
  logic [15:0] WORD_CNT;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] wa_q[$];
  logic [15:0] wd_q[$];
  int  n_acc = 0;
  int  n_ready_bad = 0;
  int  n_valid_in_write = 0;
  bit  in_load = 1'b0;
  u8_t frm[$];

  program_loader dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA), .LD_WE(LD_WE),
    .CPU_HOLD(CPU_HOLD), .DONE(DONE), .ERROR(ERROR), .WORD_CNT(WORD_CNT)
  );

  always #5 CLK = ~CLK;

  // Observe settled values 1ns after each falling edge, after the driver has updated its inputs.
  always begin
    @(negedge CLK);
    #1;
    if (LD_WE) begin
      wa_q.push_back(LD_ADDR);
      wd_q.push_back(LD_DATA);
      if (RX_VALID) n_valid_in_write++;
    end
    if (RX_VALID && RX_READY) n_acc++;
    if (in_load && (LD_WE == RX_READY)) n_ready_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    n_acc = 0;
    n_ready_bad = 0;
    n_valid_in_write = 0;
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic send_bytes(input u8_t b[$], input bit rnd);
    int idx = 0;
    int budget = 0;
    in_load = 1'b1;
    while (idx < b.size() && budget < 2000) begin
      @(negedge CLK);
      RX_DATA  = b[idx];
      RX_VALID = rnd ? (($urandom_range(0, 1) == 1) || LD_WE) : 1'b1;
      if (RX_VALID && RX_READY) idx++;
      budget++;
    end
    if (budget >= 2000) check("send_timeout", 32'(idx), 32'(b.size()));
    @(posedge CLK);
    in_load = 1'b0;
    @(negedge CLK);
    RX_VALID = 1'b0;
    @(negedge CLK);
  endtask

  task automatic check_good(input string pfx);
    check({pfx, "_nwr"}, 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2) begin
      check({pfx, "_a0"}, {16'd0, wa_q[0]}, 32'h0000);
      check({pfx, "_d0"}, {16'd0, wd_q[0]}, 32'h1234);
      check({pfx, "_a1"}, {16'd0, wa_q[1]}, 32'h0002);
      check({pfx, "_d1"}, {16'd0, wd_q[1]}, 32'h5678);
    end
    check({pfx, "_wcnt"}, {16'd0, WORD_CNT}, 32'd2);
    check({pfx, "_done"}, {31'd0, DONE}, 32'd1);
    check({pfx, "_hold"}, {31'd0, CPU_HOLD}, 32'd0);
    check({pfx, "_err"}, {30'd0, ERROR}, 32'd0);
    check({pfx, "_nacc"}, 32'(n_acc), 32'd7);
    check({pfx, "_rdy"}, 32'(n_ready_bad), 32'd0);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_rdy"}, {31'd0, RX_READY}, 32'd0);
    check({pfx, "_we"}, {31'd0, LD_WE}, 32'd0);
    check({pfx, "_addr"}, {16'd0, LD_ADDR}, 32'd0);
    check({pfx, "_data"}, {16'd0, LD_DATA}, 32'd0);
    check({pfx, "_hold"}, {31'd0, CPU_HOLD}, 32'd1);
    check({pfx, "_done"}, {31'd0, DONE}, 32'd0);
    check({pfx, "_err"}, {30'd0, ERROR}, 32'd0);
    check({pfx, "_wcnt"}, {16'd0, WORD_CNT}, 32'd0);
  endtask

  initial begin
    #12;
    check_reset("rst");
    @(negedge CLK);
    RESET_N = 1'b1;

    // Good frame, valid held high.
    clear_log();
    pulse_start();
    frm = {8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hEA};
    send_bytes(frm, 1'b0);
    check_good("good");
    check("good_heldwr", 32'(n_valid_in_write), 32'd2);

    // Bad checksum: writes still happen, CPU re-held.
    clear_log();
    pulse_start();
    check("bad_hold_on_start", {31'd0, CPU_HOLD}, 32'd1);
    check("bad_done_cleared", {31'd0, DONE}, 32'd0);
    frm = {8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hEB};
    send_bytes(frm, 1'b0);
    check("bad_nwr", 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2) check("bad_d1", {16'd0, wd_q[1]}, 32'h5678);
    check("bad_err", {30'd0, ERROR}, 32'd2);
    check("bad_done", {31'd0, DONE}, 32'd0);
    check("bad_hold", {31'd0, CPU_HOLD}, 32'd1);
    check("bad_rdy", {31'd0, RX_READY}, 32'd0);

    // Length overflow, N = 501.
    clear_log();
    pulse_start();
    check("ovf_err_cleared", {30'd0, ERROR}, 32'd0);
    frm = {8'hF5, 8'h01};
    send_bytes(frm, 1'b0);
    check("ovf_err", {30'd0, ERROR}, 32'd1);
    check("ovf_nwr", 32'(wa_q.size()), 32'd0);
    check("ovf_rdy", {31'd0, RX_READY}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      RX_DATA  = 8'(i);
      RX_VALID = 1'b1;
    end
    @(negedge CLK);
    RX_VALID = 1'b0;
    @(negedge CLK);
    check("ovf_nacc", 32'(n_acc), 32'd2);
    check("ovf_hold", {31'd0, CPU_HOLD}, 32'd1);

    // Zero-length frame.
    clear_log();
    pulse_start();
    frm = {8'h00, 8'h00, 8'h00};
    send_bytes(frm, 1'b0);
    check("zero_done", {31'd0, DONE}, 32'd1);
    check("zero_hold", {31'd0, CPU_HOLD}, 32'd0);
    check("zero_nwr", 32'(wa_q.size()), 32'd0);
    check("zero_wcnt", {16'd0, WORD_CNT}, 32'd0);
    check("zero_err", {30'd0, ERROR}, 32'd0);

    // Backpressure with random valid gaps and bytes offered during WRITE.
    clear_log();
    pulse_start();
    frm = {8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hEA};
    send_bytes(frm, 1'b1);
    check_good("bp");
    check("bp_validwr", 32'(n_valid_in_write), 32'd2);

    // Reset after the first word is written.
    clear_log();
    pulse_start();
    frm = {8'h02, 8'h00, 8'h34, 8'h12};
    send_bytes(frm, 1'b0);
    check("mid_nwr", 32'(wa_q.size()), 32'd1);
    check("mid_wcnt", {16'd0, WORD_CNT}, 32'd1);
    RESET_N = 1'b0;
    #2;
    check_reset("mid");
    @(negedge CLK);
    RESET_N = 1'b1;
    clear_log();
    pulse_start();
    frm = {8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hEA};
    send_bytes(frm, 1'b0);
    check_good("after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
